// File: rtl/ahb_dec_pkg.sv
// rtl/ahb_dec_pkg.sv - shared AHB-Lite codes and default-slave state type for the decoder/mux
package ahb_dec_pkg;

    localparam int MAX_PORTS = 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_e;

    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - two-cycle ERROR responder for unmapped transfers; error log under AHB_DECODER_ERRLOG_EN
module ahb_default_slave
    import ahb_dec_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_default,
`ifdef AHB_DECODER_ERRLOG_EN
    input  logic [31:0] haddr,
    input  logic        err_clr,
    output logic [31:0] err_addr,
    output logic [15:0] err_cnt,
`endif
    output logic        dflt_hready,
    output logic        dflt_hresp
);

    dflt_state_e state_q;
    logic        hready_q;
    logic        hresp_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_default) begin
                        state_q  <= ST_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                ST_ERR2: begin
                    // A held unmapped address phase is captured on this edge
                    if (load_default) begin
                        state_q  <= ST_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign dflt_hready = hready_q;
    assign dflt_hresp  = hresp_q;

`ifdef AHB_DECODER_ERRLOG_EN
    logic [31:0] err_addr_q, err_addr_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            err_addr_d = '0;
            err_cnt_d  = '0;
        end else if (load_default) begin
            err_addr_d = haddr;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: rtl/ahblite_decoder_mux.sv
// rtl/ahblite_decoder_mux.sv - AHB-Lite address decoder and slave response mux; optional error log via AHB_DECODER_ERRLOG_EN
module ahblite_decoder_mux
    import ahb_dec_pkg::*;
#(
    parameter int                      NUM_PORTS = 4,
    parameter logic [32*NUM_PORTS-1:0] PORT_BASE = {32'h4000_0010, 32'h0, 32'h2000_0000, 32'h0},
    parameter logic [32*NUM_PORTS-1:0] PORT_MASK = {32'hFFFF_FFF0, 32'h0, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [NUM_PORTS-1:0]    PORT_EN   = 4'b1011
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [31:0]               HADDR,
    input  logic [1:0]                HTRANS,
    output logic [NUM_PORTS-1:0]      HSEL,
    output logic                      HREADY,
    output logic [31:0]               HRDATA,
    output logic                      HRESP,
`ifdef AHB_DECODER_ERRLOG_EN
    output logic [31:0]               ERR_ADDR,
    output logic [15:0]               ERR_CNT,
    input  logic                      ERR_CLR,
`endif
    input  logic [NUM_PORTS-1:0]      HREADYOUT_S,
    input  logic [32*NUM_PORTS-1:0]   HRDATA_S,
    input  logic [NUM_PORTS-1:0]      HRESP_S
);

    // sel_q is one-hot: ports in the low bits, then DEFAULT, then NONE
    localparam int               SEL_W    = NUM_PORTS + 2;
    localparam int               DEF_IDX  = NUM_PORTS;
    localparam int               NONE_IDX = NUM_PORTS + 1;
    localparam logic [SEL_W-1:0] SEL_NONE = {1'b1, {(SEL_W-1){1'b0}}};

    logic [NUM_PORTS-1:0] match;
    logic [NUM_PORTS-1:0] hsel;
    logic                 any_match;
    logic                 active;
    logic                 load_default;
    logic                 dflt_hready;
    logic                 dflt_hresp;
    logic [SEL_W-1:0]     sel_d, sel_q;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            match[i] = PORT_EN[i] &&
                       ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]);
        end
    end

    // Walk downwards so the lowest matching index is the last one written
    always_comb begin
        hsel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hsel    = '0;
                hsel[i] = 1'b1;
            end
        end
    end

    assign HSEL         = hsel;
    assign any_match    = |match;
    assign active       = is_active(HTRANS);
    assign load_default = HREADY && !any_match && active;

    always_comb begin
        sel_d = sel_q;
        if (HREADY) begin
            sel_d = '0;
            if (any_match) begin
                sel_d[NUM_PORTS-1:0] = hsel;
            end else if (active) begin
                sel_d[DEF_IDX] = 1'b1;
            end else begin
                sel_d[NONE_IDX] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sel_q <= SEL_NONE;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q[i]) begin
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
                HRDATA = HRDATA_S[32*i +: 32];
            end
        end
        if (sel_q[DEF_IDX]) begin
            HREADY = dflt_hready;
            HRESP  = dflt_hresp;
        end
    end

    ahb_default_slave u_default_slave (
        .clk          (HCLK),
        .resetn       (HRESETn),
        .load_default (load_default),
`ifdef AHB_DECODER_ERRLOG_EN
        .haddr        (HADDR),
        .err_clr      (ERR_CLR),
        .err_addr     (ERR_ADDR),
        .err_cnt      (ERR_CNT),
`endif
        .dflt_hready  (dflt_hready),
        .dflt_hresp   (dflt_hresp)
    );

endmodule
